// File: rtl/computie_bus_trace_capture.sv
// Passive Computie bus trace capture: decodes bus cycles, filters them, and queues
// {mod, addr, data} records in a first-word fall-through FIFO under an arm/trigger/limit sequence.
module computie_bus_trace_capture #(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 32,
    parameter int CNT_W    = 16
) (
    input  logic                    cb_clk,
    input  logic                    cb_reset,
    input  logic                    cb_addr_strobe,
    input  logic                    cb_data_strobe,
    input  logic                    cb_read_write,
    input  logic [BITWIDTH-1:0]     cb_addr_data_bus,
    output logic                    addr_oe,
    output logic                    data_oe,
    input  logic                    record_start,
    input  logic                    record_stop,
    input  logic                    trigger_mode,
    input  logic                    record_trigger,
    input  logic [BITWIDTH-1:0]     filter_mask,
    input  logic [BITWIDTH-1:0]     filter_match,
    input  logic [1:0]              filter_rw,
    input  logic [CNT_W-1:0]        record_limit,
    output logic                    record_end,
    output logic                    record_valid,
    input  logic                    record_ready,
    output logic [2*BITWIDTH+1:0]   record_out,
    output logic [CNT_W-1:0]        captured_count,
    output logic [CNT_W-1:0]        dropped_count
);

    localparam int REC_W = 2*BITWIDTH + 2;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {B_ADDR, B_DATA, B_END} bus_state_t;
    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} cap_state_t;

    bus_state_t              bus_state, bus_next;
    cap_state_t              cap_state, cap_next;
    logic                    addr_oe_next, data_oe_next;
    logic                    addr_load, cycle_done;
    logic [BITWIDTH-1:0]     bus_addr;

    logic [REC_W-1:0]        mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             fill;
    logic                    gap;
    logic                    addr_hit, rw_hit, want_push, push, drop, pop, full;

    // ---------------- bus cycle decoder ----------------
    always_comb begin
        bus_next     = bus_state;
        addr_oe_next = addr_oe;
        data_oe_next = data_oe;
        addr_load    = 1'b0;
        cycle_done   = 1'b0;
        case (bus_state)
            B_ADDR: begin
                if (!cb_addr_strobe) begin
                    addr_load    = 1'b1;
                    addr_oe_next = 1'b0;
                    bus_next     = B_DATA;
                end
            end
            B_DATA: begin
                if (!cb_data_strobe) begin
                    addr_oe_next = 1'b1;
                    data_oe_next = 1'b0;
                    bus_next     = B_END;
                end else if (cb_addr_strobe) begin
                    // AS released without a data phase: abandon the cycle
                    addr_oe_next = 1'b1;
                    bus_next     = B_ADDR;
                end
            end
            B_END: begin
                if (cb_data_strobe) begin
                    data_oe_next = 1'b1;
                    cycle_done   = 1'b1;
                    bus_next     = B_ADDR;
                end
            end
            default: bus_next = B_ADDR;
        endcase
    end

    always_ff @(posedge cb_clk or negedge cb_reset) begin
        if (!cb_reset) begin
            bus_state <= B_ADDR;
            addr_oe   <= 1'b1;
            data_oe   <= 1'b1;
            bus_addr  <= '0;
        end else begin
            bus_state <= bus_next;
            addr_oe   <= addr_oe_next;
            data_oe   <= data_oe_next;
            if (addr_load)
                bus_addr <= cb_addr_data_bus;
        end
    end

    // ---------------- capture sequencing ----------------
    always_comb begin
        cap_next = cap_state;
        case (cap_state)
            IDLE:  cap_next = IDLE;
            ARMED: if (record_trigger) cap_next = RUN;
            RUN: begin
                if (((record_limit != '0) && (captured_count == record_limit)) || record_stop)
                    cap_next = DONE;
            end
            DONE:  cap_next = DONE;
            default: cap_next = IDLE;
        endcase
        if (record_start)
            cap_next = trigger_mode ? ARMED : RUN;
    end

    always_ff @(posedge cb_clk or negedge cb_reset) begin
        if (!cb_reset) cap_state <= IDLE;
        else           cap_state <= cap_next;
    end

    assign record_end = (cap_state == DONE);

    // ---------------- filter and push decision ----------------
    assign addr_hit = (((bus_addr ^ filter_match) & filter_mask) == '0);

    always_comb begin
        case (filter_rw)
            2'b01:   rw_hit = !cb_read_write;
            2'b10:   rw_hit = cb_read_write;
            default: rw_hit = 1'b1;
        endcase
    end

    assign pop       = record_valid && record_ready;
    assign full      = (fill == (AW+1)'(DEPTH));
    // a start on the same edge flushes, so any completing cycle is discarded
    assign want_push = cycle_done && (cap_state == RUN) && addr_hit && rw_hit && !record_start;
    assign push      = want_push && (!full || pop);
    assign drop      = want_push && !push;

    // ---------------- FIFO ----------------
    always_ff @(posedge cb_clk) begin
        if (push)
            mem[wr_ptr] <= {gap, cb_read_write, bus_addr, cb_addr_data_bus};
    end

    always_ff @(posedge cb_clk or negedge cb_reset) begin
        if (!cb_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (record_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign record_valid = (fill != '0);
    assign record_out   = record_valid ? mem[rd_ptr] : '0;

    // ---------------- counters and gap tracking ----------------
    always_ff @(posedge cb_clk or negedge cb_reset) begin
        if (!cb_reset) begin
            captured_count <= '0;
            dropped_count  <= '0;
            gap            <= 1'b0;
        end else if (record_start) begin
            captured_count <= '0;
            dropped_count  <= '0;
            gap            <= 1'b0;
        end else if (push) begin
            captured_count <= captured_count + CNT_W'(1);
            gap            <= 1'b0;
        end else if (drop) begin
            if (dropped_count != '1)
                dropped_count <= dropped_count + CNT_W'(1);
            gap <= 1'b1;
        end
    end

endmodule

// File: tb/tb_computie_bus_trace_capture.sv
// Randomized scoreboard bench for computie_bus_trace_capture against a transaction-level model.
module tb_computie_bus_trace_capture;

    localparam int BW    = 32;
    localparam int DEPTH = 32;
    localparam int CW    = 16;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

    logic              cb_clk = 1'b0;
    logic              cb_reset = 1'b0;
    logic              cb_addr_strobe = 1'b1;
    logic              cb_data_strobe = 1'b1;
    logic              cb_read_write = 1'b0;
    logic [BW-1:0]     cb_addr_data_bus = '0;
    logic              addr_oe, data_oe;
    logic              record_start = 1'b0;
    logic              record_stop = 1'b0;
    logic              trigger_mode = 1'b0;
    logic              record_trigger = 1'b0;
    logic [BW-1:0]     filter_mask = '0;
    logic [BW-1:0]     filter_match = '0;
    logic [1:0]        filter_rw = 2'b00;
    logic [CW-1:0]     record_limit = '0;
    logic              record_end, record_valid;
    logic              record_ready = 1'b0;
    logic [2*BW+1:0]   record_out;
    logic [CW-1:0]     captured_count, dropped_count;

    computie_bus_trace_capture #(.BITWIDTH(BW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .cb_clk(cb_clk), .cb_reset(cb_reset),
        .cb_addr_strobe(cb_addr_strobe), .cb_data_strobe(cb_data_strobe),
        .cb_read_write(cb_read_write), .cb_addr_data_bus(cb_addr_data_bus),
        .addr_oe(addr_oe), .data_oe(data_oe),
        .record_start(record_start), .record_stop(record_stop),
        .trigger_mode(trigger_mode), .record_trigger(record_trigger),
        .filter_mask(filter_mask), .filter_match(filter_match), .filter_rw(filter_rw),
        .record_limit(record_limit), .record_end(record_end),
        .record_valid(record_valid), .record_ready(record_ready), .record_out(record_out),
        .captured_count(captured_count), .dropped_count(dropped_count)
    );

    always #5 cb_clk = ~cb_clk;

    int tests = 0;
    int fails = 0;
    logic [2*BW+1:0] exp_q[$];
    int  m_state = M_IDLE;
    int  m_cnt = 0, m_drop = 0;
    bit  m_gap = 1'b0;
    bit  rand_ready = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge cb_clk);
        #1;
        if (rand_ready) record_ready = 1'($urandom_range(0, 1));
    endtask

    // scoreboard monitor: a record leaves the DUT whenever valid&ready is seen at the edge
    always @(negedge cb_clk) begin
        if (cb_reset && record_valid && record_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_record", {62'd0, record_out}, 128'd0);
            end else begin
                logic [2*BW+1:0] e;
                e = exp_q.pop_front();
                check("record_out", {62'd0, record_out}, {62'd0, e});
            end
        end
    end

    // reference: what one completed bus cycle does to the capture
    task automatic model_cycle(input logic [BW-1:0] a, input logic [BW-1:0] d, input logic rw);
        bit pass;
        pass = (((a ^ filter_match) & filter_mask) == 0);
        if (filter_rw == 2'b01 && rw)  pass = 0;
        if (filter_rw == 2'b10 && !rw) pass = 0;
        if (m_state == M_RUN && pass) begin
            if (exp_q.size() >= DEPTH) begin
                if (m_drop < 65535) m_drop++;
                m_gap = 1'b1;
            end else begin
                exp_q.push_back({m_gap, rw, a, d});
                m_gap = 1'b0;
                m_cnt = (m_cnt + 1) % 65536;
                if (record_limit != 0 && m_cnt == int'(record_limit)) m_state = M_DONE;
            end
        end
    endtask

    task automatic bus_cycle(input logic [BW-1:0] a, input logic [BW-1:0] d, input logic rw);
        cb_addr_strobe = 1'b0; cb_addr_data_bus = a; cb_read_write = rw;
        step();
        cb_data_strobe = 1'b0; cb_addr_data_bus = d;
        step();
        cb_data_strobe = 1'b1; cb_addr_strobe = 1'b1;
        step();
        model_cycle(a, d, rw);
    endtask

    task automatic abort_cycle(input logic [BW-1:0] a);
        cb_addr_strobe = 1'b0; cb_addr_data_bus = a;
        step();
        cb_addr_strobe = 1'b1;
        step();
        step();
    endtask

    task automatic start(input logic tm);
        trigger_mode = tm; record_start = 1'b1;
        step();
        record_start = 1'b0;
        exp_q.delete();
        m_cnt = 0; m_drop = 0; m_gap = 1'b0;
        m_state = tm ? M_ARMED : M_RUN;
    endtask

    task automatic stop();
        record_stop = 1'b1;
        step();
        record_stop = 1'b0;
        if (m_state == M_RUN) m_state = M_DONE;
    endtask

    task automatic trigger();
        record_trigger = 1'b1;
        step();
        record_trigger = 1'b0;
        if (m_state == M_ARMED) m_state = M_RUN;
    endtask

    task automatic check_counts(input string tag);
        step();
        check({tag, "_captured"}, 128'(captured_count), 128'(m_cnt));
        check({tag, "_dropped"},  128'(dropped_count),  128'(m_drop));
        check({tag, "_end"},      128'(record_end),     128'(m_state == M_DONE));
    endtask

    task automatic drain(input string tag);
        int n;
        rand_ready = 1'b0; record_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            step(); n++;
        end
        step(); step();
        check({tag, "_drain_left"}, 128'(exp_q.size()), 128'd0);
        check({tag, "_drain_valid"}, 128'(record_valid), 128'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr_oe"}, 128'(addr_oe), 128'd1);
        check({tag, "_data_oe"}, 128'(data_oe), 128'd1);
        check({tag, "_valid"},   128'(record_valid), 128'd0);
        check({tag, "_end"},     128'(record_end), 128'd0);
        check({tag, "_out"},     128'(record_out), 128'd0);
        check({tag, "_counts"},  128'({captured_count, dropped_count}), 128'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*BW+1:0] want;
        #12;
        check_reset_outputs("reset");
        cb_reset = 1'b1;
        step();

        // 1: single write, head valid one cycle after DS rises
        record_ready = 1'b1;
        start(1'b0);
        bus_cycle(32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
        want = {2'b00, 32'h0000_1000, 32'hDEAD_BEEF};
        check("t1_valid", 128'(record_valid), 128'd1);
        check("t1_out",   128'(record_out), 128'(want));
        check("t1_captured", 128'(captured_count), 128'd1);
        drain("t1");

        // 2: address filter
        filter_mask = 32'hFFFF_0000; filter_match = 32'h0020_0000;
        start(1'b0);
        bus_cycle(32'h0020_0010, 32'h1111_1111, 1'b0);
        bus_cycle(32'h0030_0010, 32'h2222_2222, 1'b1);
        check_counts("t2");
        check("t2_captured_fixed", 128'(captured_count), 128'd1);
        drain("t2");
        filter_mask = '0; filter_match = '0;

        // 3: arm then trigger
        start(1'b1);
        for (int i = 0; i < 3; i++) bus_cycle($urandom, $urandom, 1'($urandom));
        check_counts("t3_armed");
        trigger();
        for (int i = 0; i < 2; i++) bus_cycle($urandom, $urandom, 1'($urandom));
        check("t3_captured_fixed", 128'(captured_count), 128'd2);
        drain("t3");

        // 4: overflow, then gap marker on the first record after the drop
        record_ready = 1'b0;
        start(1'b0);
        for (int i = 0; i < DEPTH + 3; i++) bus_cycle(32'h4000 + i, $urandom, 1'b0);
        check_counts("t4_full");
        check("t4_dropped_fixed", 128'(dropped_count), 128'd3);
        drain("t4");
        record_ready = 1'b0;
        bus_cycle(32'h5000, 32'hAAAA_0001, 1'b1);
        bus_cycle(32'h5004, 32'hAAAA_0002, 1'b1);
        check("t4_gap_set", 128'(record_out[2*BW+1]), 128'd1);
        drain("t4b");

        // 5: record limit
        record_limit = 16'd4;
        start(1'b0);
        for (int i = 0; i < 6; i++) bus_cycle($urandom, $urandom, 1'($urandom));
        check_counts("t5");
        check("t5_end_fixed", 128'({record_end, captured_count}), 128'({1'b1, 16'd4}));
        drain("t5");
        start(1'b0);
        check_counts("t5_restart");
        record_limit = '0;

        // 6: reset during B_END with records queued, then an aborted cycle
        record_ready = 1'b0;
        bus_cycle(32'h6000, 32'h6666_0000, 1'b0);
        bus_cycle(32'h6004, 32'h6666_0004, 1'b1);
        cb_addr_strobe = 1'b0; cb_addr_data_bus = 32'h6008;
        step();
        cb_data_strobe = 1'b0;
        step();
        cb_reset = 1'b0;
        #1;
        exp_q.delete(); m_state = M_IDLE; m_cnt = 0; m_drop = 0; m_gap = 1'b0;
        check_reset_outputs("t6_reset");
        step();
        cb_data_strobe = 1'b1; cb_addr_strobe = 1'b1;
        cb_reset = 1'b1;
        step();
        start(1'b0);
        abort_cycle(32'h7000);
        check_counts("t6_abort");
        check("t6_abort_valid", 128'(record_valid), 128'd0);
        bus_cycle(32'h7004, 32'h7777_7777, 1'b0);
        check_counts("t6_after");
        drain("t6");

        // randomized rounds with random filters, ready and trigger/limit settings
        for (int r = 0; r < 4; r++) begin
            logic tm;
            tm = 1'(r % 2);
            case ($urandom_range(0, 2))
                0: filter_mask = '0;
                1: filter_mask = 32'hFFFF_0000;
                default: filter_mask = 32'h0000_000F;
            endcase
            filter_match = $urandom;
            filter_rw = 2'($urandom_range(0, 3));
            record_limit = tm ? 16'($urandom_range(3, 8)) : 16'd0;
            rand_ready = 1'b1;
            start(tm);
            for (int i = 0; i < 30; i++) begin
                logic [BW-1:0] a;
                a = $urandom;
                if ($urandom_range(0, 1) == 1) a = (a & ~filter_mask) | (filter_match & filter_mask);
                if (tm && i == 5) trigger();
                bus_cycle(a, $urandom, 1'($urandom));
                repeat ($urandom_range(0, 2)) step();
            end
            check_counts("rand");
            stop();
            check_counts("rand_stop");
            drain("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
